// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory port bundle for the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ctl_mem_re;
  logic        ctl_mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ctl_mem_re, ctl_mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ctl_mem_re, ctl_mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RISC-V load/store engine; sub-word stores use read-modify-write
// because the data memory only writes whole words.
module load_store_unit #(
  parameter int ADDR_LIMIT = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wd_q;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        err;
  logic [15:0] sh;
  logic [31:0] ld;
  logic [31:0] mask;
  logic [31:0] merged;
  always_comb begin
    illegal      = (bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3[2] & (bus.req_we | bus.req_funct3[1]));
    misaligned   = (bus.req_funct3[0] & bus.req_addr[0]) | (bus.req_funct3[1] & |bus.req_addr[1:0]);
    out_of_range = {2'b00, bus.req_addr[31:2]} >= 32'(ADDR_LIMIT / 4);
    err          = illegal | misaligned | out_of_range;
    // low 16 bits of the word after shifting the addressed lane down to lane 0
    sh     = 16'(bus.mem_rdata >> {lane_q, 3'b000});
    ld     = f3_q[1] ? bus.mem_rdata :
             f3_q[0] ? {(f3_q[2] ? 16'h0000 : {16{sh[15]}}), sh} :
                       {(f3_q[2] ? 24'h000000 : {24{sh[7]}}), sh[7:0]};
    mask   = (f3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << {lane_q, 3'b000};
    merged = (bus.mem_rdata & ~mask) | ((wd_q << {lane_q, 3'b000}) & mask);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      lane_q         <= 2'b00;
      wd_q           <= 32'h0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= 32'h0;
      bus.rsp_err    <= 1'b0;
      bus.ctl_mem_re <= 1'b0;
      bus.ctl_mem_we <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q          <= bus.req_we;
          f3_q          <= bus.req_funct3;
          lane_q        <= bus.req_addr[1:0];
          wd_q          <= bus.req_wdata;
          bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
          bus.req_ready <= 1'b0;
          if (err) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= 32'h0;
          end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
            state          <= WRITE;
            bus.ctl_mem_we <= 1'b1;
            bus.mem_wdata  <= bus.req_wdata;
          end else begin
            state          <= READ;
            bus.ctl_mem_re <= 1'b1;
          end
        end
        READ: begin
          state          <= WAIT;
          bus.ctl_mem_re <= 1'b0;
        end
        WAIT: if (we_q) begin
          state          <= WRITE;
          bus.mem_wdata  <= merged;
          bus.ctl_mem_we <= 1'b1;
        end else begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= ld;
          bus.rsp_err   <= 1'b0;
        end
        WRITE: begin
          state          <= RESP;
          bus.ctl_mem_we <= 1'b0;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_rdata  <= 32'h0;
          bus.rsp_err    <= 1'b0;
        end
        RESP: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed checks of the load/store unit against a word memory model,
// plus hand-written reset-during-RMW and back-to-back sequences.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  load_store_unit_if bus();
  load_store_unit #(.ADDR_LIMIT(512)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] mem [0:127];
  logic        pre_en = 1'b0;
  logic [6:0]  pre_a = 7'd0;
  logic [31:0] pre_d = 32'h0;
  int          wr_cnt = 0;
  int          ovl = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) mem[pre_a] <= pre_d;
    if (bus.ctl_mem_we) begin
      mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.ctl_mem_re) bus.mem_rdata <= mem[bus.mem_addr[8:2]];
  end
  always @(negedge clk) if (bus.ctl_mem_re && bus.ctl_mem_we) ovl <= ovl + 1;
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_re;
    int          exp_we;
    int          exp_rsp;
    logic [31:0] exp_wd;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input logic e, input int re, input int wr, input int rsp, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = rd; v.exp_err = e;
    v.exp_re = re; v.exp_we = wr; v.exp_rsp = rsp; v.exp_wd = wd;
    return v;
  endfunction
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
  endtask
  task automatic run(input int i, input vec_t v);
    int t_re, t_we, t_rsp;
    logic [31:0] wd, ad, rd;
    logic er;
    t_re = 0; t_we = 0; t_rsp = 0; wd = 0; ad = 0; rd = 0; er = 0;
    @(negedge clk);
    chk($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'd1);
    drive(v.we, v.f3, v.addr, v.wdata);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8 && t_rsp == 0; k++) begin
      @(negedge clk);
      if (k == 1) ad = bus.mem_addr;
      if (bus.ctl_mem_re && t_re == 0) t_re = k;
      if (bus.ctl_mem_we && t_we == 0) begin t_we = k; wd = bus.mem_wdata; end
      if (bus.rsp_valid) begin t_rsp = k; rd = bus.rsp_rdata; er = bus.rsp_err; end
    end
    chk($sformatf("v%0d rsp_cycle", i), 32'(t_rsp), 32'(v.exp_rsp));
    chk($sformatf("v%0d err", i), 32'(er), 32'(v.exp_err));
    chk($sformatf("v%0d rdata", i), rd, v.exp_rdata);
    chk($sformatf("v%0d re_cycle", i), 32'(t_re), 32'(v.exp_re));
    chk($sformatf("v%0d we_cycle", i), 32'(t_we), 32'(v.exp_we));
    chk($sformatf("v%0d mem_addr", i), ad, {v.addr[31:2], 2'b00});
    if (v.exp_we != 0) chk($sformatf("v%0d mem_wdata", i), wd, v.exp_wd);
  endtask
  vec_t vt [20];
  logic        bw_we [3];
  logic [2:0]  bw_f3 [3];
  logic [31:0] bw_ad [3];
  logic [31:0] bw_wd [3];
  initial begin
    int w0;
    int acc0, idx, nrsp;
    bit pend;
    int rc [3];
    logic [31:0] rdv [3];
    logic rev [3];
    // columns: we f3 addr wdata | rdata err re_cycle we_cycle rsp_cycle write_word
    vt[0]  = mk(1, 3'b010, 32'h010, 32'h80F122A5, 32'h0,        0, 0, 1, 2, 32'h80F122A5);
    vt[1]  = mk(0, 3'b010, 32'h010, 32'h0,        32'h80F122A5, 0, 1, 0, 3, 32'h0);
    vt[2]  = mk(0, 3'b000, 32'h010, 32'h0,        32'hFFFFFFA5, 0, 1, 0, 3, 32'h0);
    vt[3]  = mk(0, 3'b100, 32'h013, 32'h0,        32'h00000080, 0, 1, 0, 3, 32'h0);
    vt[4]  = mk(0, 3'b001, 32'h012, 32'h0,        32'hFFFF80F1, 0, 1, 0, 3, 32'h0);
    vt[5]  = mk(0, 3'b101, 32'h010, 32'h0,        32'h000022A5, 0, 1, 0, 3, 32'h0);
    vt[6]  = mk(1, 3'b000, 32'h011, 32'hDEADBE77, 32'h0,        0, 1, 3, 4, 32'h80F177A5);
    vt[7]  = mk(1, 3'b001, 32'h012, 32'h00001234, 32'h0,        0, 1, 3, 4, 32'h123477A5);
    vt[8]  = mk(0, 3'b010, 32'h010, 32'h0,        32'h123477A5, 0, 1, 0, 3, 32'h0);
    vt[9]  = mk(0, 3'b010, 32'h012, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0);
    vt[10] = mk(0, 3'b001, 32'h011, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0);
    vt[11] = mk(0, 3'b010, 32'h200, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0);
    vt[12] = mk(0, 3'b011, 32'h010, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0);
    vt[13] = mk(1, 3'b100, 32'h010, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0);
    vt[14] = mk(1, 3'b010, 32'h1FC, 32'hCAFEF00D, 32'h0,        0, 0, 1, 2, 32'hCAFEF00D);
    vt[15] = mk(0, 3'b010, 32'h1FC, 32'h0,        32'hCAFEF00D, 0, 1, 0, 3, 32'h0);
    vt[16] = mk(1, 3'b000, 32'h1FF, 32'h00000011, 32'h0,        0, 1, 3, 4, 32'h11FEF00D);
    vt[17] = mk(1, 3'b001, 32'h013, 32'h0000BEEF, 32'h0,        1, 0, 0, 1, 32'h0);
    vt[18] = mk(0, 3'b100, 32'h1FF, 32'h0,        32'h00000011, 0, 1, 0, 3, 32'h0);
    vt[19] = mk(0, 3'b000, 32'h1FE, 32'h0,        32'hFFFFFFFE, 0, 1, 0, 3, 32'h0);
    bus.req_valid = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset re_we", {30'd0, bus.ctl_mem_re, bus.ctl_mem_we}, 32'd0);
    chk("reset rdata", bus.rsp_rdata, 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) run(i, vt[i]);
    // reset during WAIT of SB 0x10 must drop the store without a write
    @(negedge clk);
    pre_a = 7'd4; pre_d = 32'h11223344; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    w0 = wr_cnt;
    drive(1'b1, 3'b000, 32'h010, 32'h000000FF);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq re_in_read", 32'(bus.ctl_mem_re), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_seq ready", 32'(bus.req_ready), 32'd1);
    chk("rst_seq flags", {28'd0, bus.rsp_valid, bus.rsp_err, bus.ctl_mem_re, bus.ctl_mem_we}, 32'd0);
    chk("rst_seq rdata", bus.rsp_rdata, 32'h0);
    chk("rst_seq mem_addr", bus.mem_addr, 32'h0);
    chk("rst_seq mem_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seq no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_seq no_write", 32'(wr_cnt - w0), 32'd0);
    run(100, mk(0, 3'b010, 32'h010, 32'h0, 32'h11223344, 0, 1, 0, 3, 32'h0));
    // back-to-back: valid held high, next request presented after each accept
    bw_we[0] = 0; bw_f3[0] = 3'b010; bw_ad[0] = 32'h010; bw_wd[0] = 32'h0;
    bw_we[1] = 1; bw_f3[1] = 3'b010; bw_ad[1] = 32'h014; bw_wd[1] = 32'h5555AAAA;
    bw_we[2] = 0; bw_f3[2] = 3'b000; bw_ad[2] = 32'h014; bw_wd[2] = 32'h0;
    acc0 = 0; idx = 0; nrsp = 0; pend = 0;
    for (int j = 0; j < 3; j++) begin rc[j] = -1; rdv[j] = 32'hx; rev[j] = 1'bx; end
    @(negedge clk);
    drive(bw_we[0], bw_f3[0], bw_ad[0], bw_wd[0]);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.rsp_valid) begin
        if (nrsp < 3) begin rc[nrsp] = cyc - acc0; rdv[nrsp] = bus.rsp_rdata; rev[nrsp] = bus.rsp_err; end
        nrsp++;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (idx == 0) acc0 = cyc + 1;
        pend = 1;
      end
      @(negedge clk);
      if (pend) begin
        pend = 0;
        idx++;
        if (idx < 3) drive(bw_we[idx], bw_f3[idx], bw_ad[idx], bw_wd[idx]);
        else bus.req_valid = 1'b0;
      end
    end
    chk("b2b rsp_count", 32'(nrsp), 32'd3);
    chk("b2b lw_cycle", 32'(rc[0]), 32'd2);
    chk("b2b sw_cycle", 32'(rc[1]), 32'd5);
    chk("b2b lb_cycle", 32'(rc[2]), 32'd9);
    chk("b2b lw_rdata", rdv[0], 32'h11223344);
    chk("b2b sw_rdata", rdv[1], 32'h0);
    chk("b2b lb_rdata", rdv[2], 32'hFFFFFFAA);
    chk("b2b errs", {29'd0, rev[0], rev[1], rev[2]}, 32'd0);
    chk("re_we_exclusive", 32'(ovl), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
